// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one iteration per clock, 33-cycle busy window.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [1:0]  state_r;
  logic [4:0]  cnt_r;
  logic        is_div_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        div_zero_r;
  logic [31:0] a_mag_r;
  logic [31:0] b_mag_r;
  logic [31:0] acc_r;
  logic [31:0] quo_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;

  logic [1:0]  state_nxt_s;
  logic [4:0]  cnt_nxt_s;
  logic        is_div_nxt_s;
  logic        neg_q_nxt_s;
  logic        neg_r_nxt_s;
  logic        div_zero_nxt_s;
  logic [31:0] a_mag_nxt_s;
  logic [31:0] b_mag_nxt_s;
  logic [31:0] acc_nxt_s;
  logic [31:0] quo_nxt_s;
  logic [31:0] hi_nxt_s;
  logic [31:0] lo_nxt_s;
  logic        busy_nxt_s;

  logic        sign_a_s;
  logic        sign_b_s;
  logic [31:0] in_a_mag_s;
  logic [31:0] in_b_mag_s;
  logic [32:0] sum_s;
  logic [32:0] shift_s;
  logic        ge_s;
  logic [63:0] prod_s;
  logic [63:0] prod_fix_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = 32'd0 - v;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] v);
    if (neg) begin
      cond_neg32 = 32'd0 - v;
    end else begin
      cond_neg32 = v;
    end
  endfunction

  // Datapath step and next-state selection for the whole unit.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    is_div_nxt_s   = is_div_r;
    neg_q_nxt_s    = neg_q_r;
    neg_r_nxt_s    = neg_r_r;
    div_zero_nxt_s = div_zero_r;
    a_mag_nxt_s    = a_mag_r;
    b_mag_nxt_s    = b_mag_r;
    acc_nxt_s      = acc_r;
    quo_nxt_s      = quo_r;
    hi_nxt_s       = hi_r;
    lo_nxt_s       = lo_r;

    // op[0]=0 selects the signed variants (MULT, DIV).
    sign_a_s   = ~op[0] & operand_a[31];
    sign_b_s   = ~op[0] & operand_b[31];
    in_a_mag_s = cond_neg32(sign_a_s, operand_a);
    in_b_mag_s = cond_neg32(sign_b_s, operand_b);

    sum_s      = {1'b0, acc_r} + (quo_r[0] ? {1'b0, a_mag_r} : 33'd0);
    shift_s    = {acc_r, quo_r[31]};
    ge_s       = (shift_s >= {1'b0, b_mag_r});
    prod_s     = {acc_r, quo_r};
    prod_fix_s = neg_q_r ? (64'd0 - prod_s) : prod_s;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          is_div_nxt_s   = op[1];
          neg_q_nxt_s    = sign_a_s ^ sign_b_s;
          neg_r_nxt_s    = sign_a_s;
          div_zero_nxt_s = (operand_b == 32'd0);
          a_mag_nxt_s    = in_a_mag_s;
          b_mag_nxt_s    = in_b_mag_s;
          acc_nxt_s      = 32'd0;
          quo_nxt_s      = op[1] ? in_a_mag_s : in_b_mag_s;
          cnt_nxt_s      = 5'd31;
          state_nxt_s    = ST_RUN;
        end else begin
          if (hi_we) begin
            hi_nxt_s = wdata;
          end else begin
            hi_nxt_s = hi_r;
          end
          if (lo_we) begin
            lo_nxt_s = wdata;
          end else begin
            lo_nxt_s = lo_r;
          end
        end
      end
      ST_RUN: begin
        if (is_div_r) begin
          if (ge_s) begin
            acc_nxt_s = shift_s[31:0] - b_mag_r;
            quo_nxt_s = {quo_r[30:0], 1'b1};
          end else begin
            acc_nxt_s = shift_s[31:0];
            quo_nxt_s = {quo_r[30:0], 1'b0};
          end
        end else begin
          acc_nxt_s = sum_s[32:1];
          quo_nxt_s = {sum_s[0], quo_r[31:1]};
        end
        if (cnt_r == 5'd0) begin
          state_nxt_s = ST_FINISH;
        end else begin
          cnt_nxt_s = cnt_r - 5'd1;
        end
      end
      ST_FINISH: begin
        if (!is_div_r) begin
          hi_nxt_s = prod_fix_s[63:32];
          lo_nxt_s = prod_fix_s[31:0];
        end else if (div_zero_r) begin
          // Divide by zero returns all-ones quotient and the original dividend.
          hi_nxt_s = neg_r_r ? neg32(a_mag_r) : a_mag_r;
          lo_nxt_s = 32'hFFFF_FFFF;
        end else begin
          hi_nxt_s = cond_neg32(neg_r_r, acc_r);
          lo_nxt_s = cond_neg32(neg_q_r, quo_r);
        end
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 5'd0;
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
      a_mag_r    <= 32'd0;
      b_mag_r    <= 32'd0;
      acc_r      <= 32'd0;
      quo_r      <= 32'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      is_div_r   <= is_div_nxt_s;
      neg_q_r    <= neg_q_nxt_s;
      neg_r_r    <= neg_r_nxt_s;
      div_zero_r <= div_zero_nxt_s;
      a_mag_r    <= a_mag_nxt_s;
      b_mag_r    <= b_mag_nxt_s;
      acc_r      <= acc_nxt_s;
      quo_r      <= quo_nxt_s;
      hi_r       <= hi_nxt_s;
      lo_r       <= lo_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= (state_r == ST_FINISH);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 start  input  1  request a new operation; sampled only when busy=0.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 operand_a  input  32  rs value from the register file read port 1 (multiplicand/dividend).
REQ-007 operand_b  input  32  rt value from the register file read port 2 (multiplier/divisor).
REQ-008 hi_we  input  1  MTHI write enable.
REQ-009 lo_we  input  1  MTLO write enable.
REQ-010 wdata  input  32  MTHI/MTLO data.
REQ-011 busy  output  1  high while an operation is in flight.
REQ-012 done  output  1  one-cycle pulse when HI/LO receive a result.
REQ-013 hi  output  32  HI register, feeds MFHI write-back to the register file.
REQ-014 lo  output  32  LO register, feeds MFLO write-back to the register file.

Function
REQ-015 States: IDLE, RUN, FINISH; busy SHALL be 1 exactly when the state is not IDLE.
REQ-016 IDLE with start=1 at edge E0: latch op, latch |operand| for signed ops (raw for unsigned), record result signs, load 5-bit counter with 31, go to RUN.
REQ-017 RUN: one iteration per edge (shift-add multiply, restoring divide); decrement counter; the iteration with counter=0 goes to FINISH; iterations occur on E1..E32.
REQ-018 FINISH at E33: apply sign correction, write HI/LO, set done=1 for the following cycle only, return to IDLE.
REQ-019 Latency: result visible on hi/lo and done=1 in the cycle after E33; busy=1 for exactly 33 cycles.
REQ-020 MULT/MULTU: {hi,lo} = 64-bit product, two's-complement for MULT.
REQ-021 DIV/DIVU: lo = quotient truncated toward zero; hi = remainder whose sign matches the dividend.
REQ-022 Divide by zero: lo = 32'hFFFFFFFF, hi = original operand_a; latency unchanged (33 cycles).
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000 (modulo-2^32 wrap), no error flag.
REQ-024 start while busy=1 SHALL be ignored; the in-flight operation and its operands are unaffected.
REQ-025 hi_we/lo_we in IDLE write wdata to hi/lo on the same edge; hi_we and lo_we together write both.
REQ-026 hi_we/lo_we while busy=1 SHALL be ignored.
REQ-027 start and hi_we/lo_we in the same IDLE cycle: start wins and the write is dropped.
REQ-028 hi/lo SHALL hold their values between operations and throughout RUN; they change only in FINISH, on an MTHI/MTLO write, or on reset.
REQ-029 operand_a/operand_b changes after E0 SHALL have no effect.

Reset
REQ-030 reset=0 at a clock edge: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators cleared.
REQ-031 Reset in RUN or FINISH aborts the operation; no partial result reaches hi/lo and done does not pulse.
REQ-032 reset has priority over start, hi_we and lo_we in the same cycle.

Verification
REQ-033 MULT 0xFFFFFFFF x 0x00000002 -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once; MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 2 -> lo=3, hi=1.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234 after 33 cycles.
REQ-036 MULTU 3x4 started; start with new operands plus hi_we=1 (wdata=0xDEAD) at cycle 5 -> both ignored, result hi=0, lo=12 at cycle 33.
REQ-037 MULTU started; reset=0 at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; a new start then completes normally.
REQ-038 IDLE hi_we=1 (wdata=0x12345678) -> hi=0x12345678 next cycle; lo_we with start in the same cycle -> start runs and lo is not written.
